// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle RV32 control FSM: states, ALU op codes,
// writeback selects, opcodes and the decode helpers used by the controller.
package multicycle_control_pkg;

  typedef enum logic [2:0] {
    ST_FETCH       = 3'd0,
    ST_DECODE      = 3'd1,
    ST_EXECUTE     = 3'd2,
    ST_MEM         = 3'd3,
    ST_MULDIV_WAIT = 3'd4,
    ST_WRITEBACK   = 3'd5,
    ST_TRAP        = 3'd6
  } state_e;

  localparam logic [2:0] ALU_ZERO      = 3'b000;
  localparam logic [2:0] ALU_ADD       = 3'b001;
  localparam logic [2:0] ALU_DEFAULT   = 3'b010;
  localparam logic [2:0] ALU_SECONDARY = 3'b011;
  localparam logic [2:0] ALU_MULDIV    = 3'b101;

  localparam logic [2:0] WB_ALU  = 3'b000;
  localparam logic [2:0] WB_MEM  = 3'b001;
  localparam logic [2:0] WB_LINK = 3'b010;
  localparam logic [2:0] WB_IMM  = 3'b011;

  localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
  localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
  localparam logic [6:0] OPCODE_OP       = 7'b0110011;
  localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
  localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
  localparam logic [6:0] OPCODE_JAL      = 7'b1101111;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       a_sel;
    logic       b_sel;
  } alu_ctrl_t;

  function automatic logic opcode_supported(input logic [6:0] op);
    logic ok;
    case (op)
      OPCODE_LOAD, OPCODE_MISC_MEM, OPCODE_OP_IMM, OPCODE_AUIPC, OPCODE_STORE,
      OPCODE_OP, OPCODE_LUI, OPCODE_BRANCH, OPCODE_JALR, OPCODE_JAL: ok = 1'b1;
      default:                                                       ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Secondary op (bit30) takes precedence over the M-extension select.
  function automatic alu_ctrl_t alu_decode(input logic [6:0] op, input logic b30,
                                           input logic b25, input logic m_ext);
    alu_ctrl_t c;
    c.alu_op = ALU_ZERO;
    c.a_sel  = 1'b0;
    c.b_sel  = 1'b0;
    case (op)
      OPCODE_OP: begin
        if (b30)                c.alu_op = ALU_SECONDARY;
        else if (m_ext && b25)  c.alu_op = ALU_MULDIV;
        else                    c.alu_op = ALU_DEFAULT;
      end
      OPCODE_OP_IMM: begin
        c.alu_op = ALU_DEFAULT;
        c.b_sel  = 1'b1;
      end
      OPCODE_LOAD, OPCODE_STORE, OPCODE_JALR: begin
        c.alu_op = ALU_ADD;
        c.b_sel  = 1'b1;
      end
      OPCODE_AUIPC, OPCODE_JAL: begin
        c.alu_op = ALU_ADD;
        c.a_sel  = 1'b1;
        c.b_sel  = 1'b1;
      end
      OPCODE_BRANCH: c.alu_op = ALU_ADD;
      default:       c.alu_op = ALU_ZERO;
    endcase
    return c;
  endfunction

  function automatic logic [2:0] wb_select(input logic [6:0] op);
    logic [2:0] s;
    case (op)
      OPCODE_LOAD:              s = WB_MEM;
      OPCODE_JAL, OPCODE_JALR:  s = WB_LINK;
      OPCODE_LUI:               s = WB_IMM;
      default:                  s = WB_ALU;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Multicycle RV32 control FSM: fetch/decode/execute/mem/muldiv/writeback with
// bounded memory waits and a sticky trap for illegal opcodes or timeouts.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter int M_EXTENSION  = 0,
  parameter int MAX_MEM_WAIT = 15
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [6:0] inst_opcode,
  input  logic       inst_bit_30,
  input  logic       inst_bit_25,
  input  logic       inst_mem_ready,
  input  logic       data_mem_ready,
  input  logic       muldiv_done,
  output logic       pc_write_enable,
  output logic       ir_write_enable,
  output logic       inst_mem_read_enable,
  output logic       regfile_write_enable,
  output logic       alu_operand_a_select,
  output logic       alu_operand_b_select,
  output logic [2:0] alu_op_type,
  output logic       jal_enable,
  output logic       jalr_enable,
  output logic       branch_enable,
  output logic       data_mem_read_enable,
  output logic       data_mem_write_enable,
  output logic [2:0] reg_writeback_select,
  output logic       muldiv_start,
  output logic       illegal_instruction,
  output logic       mem_timeout
);

  localparam int              CNT_W      = $clog2(MAX_MEM_WAIT + 1);
  localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(MAX_MEM_WAIT);
  localparam logic            M_EN       = (M_EXTENSION != 0);

  state_e           state, state_next;
  logic [CNT_W-1:0] wait_cnt;
  logic [6:0]       opcode_q;
  logic             bit30_q, bit25_q;
  logic             wait_inc, timeout_hit, illegal_hit;
  alu_ctrl_t        alu_c;
  logic             is_muldiv;

  assign alu_c     = alu_decode(opcode_q, bit30_q, bit25_q, M_EN);
  assign is_muldiv = (alu_c.alu_op == ALU_MULDIV);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_FETCH;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    wait_inc    = 1'b0;
    timeout_hit = 1'b0;
    illegal_hit = 1'b0;
    case (state)
      ST_FETCH: begin
        if (inst_mem_ready) begin
          state_next = ST_DECODE;
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_next  = ST_TRAP;
          timeout_hit = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_DECODE: begin
        if (opcode_supported(opcode_q)) begin
          state_next = ST_EXECUTE;
        end else begin
          state_next  = ST_TRAP;
          illegal_hit = 1'b1;
        end
      end
      ST_EXECUTE: begin
        if (opcode_q == OPCODE_LOAD || opcode_q == OPCODE_STORE)          state_next = ST_MEM;
        else if (is_muldiv)                                               state_next = ST_MULDIV_WAIT;
        else if (opcode_q == OPCODE_BRANCH || opcode_q == OPCODE_MISC_MEM) state_next = ST_FETCH;
        else                                                              state_next = ST_WRITEBACK;
      end
      ST_MEM: begin
        if (data_mem_ready) begin
          state_next = (opcode_q == OPCODE_LOAD) ? ST_WRITEBACK : ST_FETCH;
        end else if (wait_cnt == WAIT_LIMIT) begin
          state_next  = ST_TRAP;
          timeout_hit = 1'b1;
        end else begin
          wait_inc = 1'b1;
        end
      end
      ST_MULDIV_WAIT: if (muldiv_done) state_next = ST_WRITEBACK;
      ST_WRITEBACK:   state_next = ST_FETCH;
      ST_TRAP:        state_next = ST_TRAP;
      default:        state_next = ST_FETCH;
    endcase
  end

  always_comb begin
    pc_write_enable       = 1'b0;
    ir_write_enable       = 1'b0;
    inst_mem_read_enable  = 1'b0;
    regfile_write_enable  = 1'b0;
    alu_operand_a_select  = 1'b0;
    alu_operand_b_select  = 1'b0;
    alu_op_type           = ALU_ZERO;
    jal_enable            = 1'b0;
    jalr_enable           = 1'b0;
    branch_enable         = 1'b0;
    data_mem_read_enable  = 1'b0;
    data_mem_write_enable = 1'b0;
    reg_writeback_select  = WB_ALU;
    muldiv_start          = 1'b0;
    if (state inside {ST_EXECUTE, ST_MEM, ST_MULDIV_WAIT, ST_WRITEBACK}) begin
      alu_op_type          = alu_c.alu_op;
      alu_operand_a_select = alu_c.a_sel;
      alu_operand_b_select = alu_c.b_sel;
    end
    case (state)
      ST_FETCH: begin
        inst_mem_read_enable = 1'b1;
        ir_write_enable      = inst_mem_ready;
      end
      ST_EXECUTE: begin
        if (opcode_q == OPCODE_BRANCH) begin
          branch_enable   = 1'b1;
          pc_write_enable = 1'b1;
        end
        if (opcode_q == OPCODE_MISC_MEM) pc_write_enable = 1'b1;
        muldiv_start = is_muldiv;
      end
      ST_MEM: begin
        data_mem_read_enable  = (opcode_q == OPCODE_LOAD);
        data_mem_write_enable = (opcode_q == OPCODE_STORE);
        // A store retires in the cycle its write completes.
        pc_write_enable       = (opcode_q == OPCODE_STORE) && data_mem_ready;
      end
      ST_WRITEBACK: begin
        regfile_write_enable = 1'b1;
        pc_write_enable      = 1'b1;
        jal_enable           = (opcode_q == OPCODE_JAL);
        jalr_enable          = (opcode_q == OPCODE_JALR);
        reg_writeback_select = wb_select(opcode_q);
      end
      default: ;
    endcase
  end

  // Counter runs only while waiting; any other cycle (including entry to
  // FETCH or MEM) leaves it cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)        wait_cnt <= '0;
    else if (wait_inc) wait_cnt <= wait_cnt + CNT_W'(1);
    else               wait_cnt <= '0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opcode_q <= '0;
      bit30_q  <= 1'b0;
      bit25_q  <= 1'b0;
    end else if (state == ST_FETCH && inst_mem_ready) begin
      opcode_q <= inst_opcode;
      bit30_q  <= inst_bit_30;
      bit25_q  <= inst_bit_25;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      illegal_instruction <= 1'b0;
      mem_timeout         <= 1'b0;
    end else begin
      if (illegal_hit) illegal_instruction <= 1'b1;
      if (timeout_hit) mem_timeout         <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (M extension on, 4-cycle memory wait limit).
module tb_multicycle_control;

  logic       clock, reset;
  logic [6:0] inst_opcode;
  logic       inst_bit_30, inst_bit_25;
  logic       inst_mem_ready, data_mem_ready, muldiv_done;
  logic       pc_write_enable, ir_write_enable, inst_mem_read_enable, regfile_write_enable;
  logic       alu_operand_a_select, alu_operand_b_select;
  logic [2:0] alu_op_type;
  logic       jal_enable, jalr_enable, branch_enable;
  logic       data_mem_read_enable, data_mem_write_enable;
  logic [2:0] reg_writeback_select;
  logic       muldiv_start, illegal_instruction, mem_timeout;

  int checks = 0;
  int errors = 0;

  multicycle_control #(.M_EXTENSION(1), .MAX_MEM_WAIT(4)) dut (
    .clock(clock), .reset(reset),
    .inst_opcode(inst_opcode), .inst_bit_30(inst_bit_30), .inst_bit_25(inst_bit_25),
    .inst_mem_ready(inst_mem_ready), .data_mem_ready(data_mem_ready), .muldiv_done(muldiv_done),
    .pc_write_enable(pc_write_enable), .ir_write_enable(ir_write_enable),
    .inst_mem_read_enable(inst_mem_read_enable), .regfile_write_enable(regfile_write_enable),
    .alu_operand_a_select(alu_operand_a_select), .alu_operand_b_select(alu_operand_b_select),
    .alu_op_type(alu_op_type), .jal_enable(jal_enable), .jalr_enable(jalr_enable),
    .branch_enable(branch_enable), .data_mem_read_enable(data_mem_read_enable),
    .data_mem_write_enable(data_mem_write_enable), .reg_writeback_select(reg_writeback_select),
    .muldiv_start(muldiv_start), .illegal_instruction(illegal_instruction), .mem_timeout(mem_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // {pc, ir, imem_rd, rf_we, dmem_rd, dmem_wr, muldiv_start, branch}
  function automatic logic [7:0] ctl();
    return {pc_write_enable, ir_write_enable, inst_mem_read_enable, regfile_write_enable,
            data_mem_read_enable, data_mem_write_enable, muldiv_start, branch_enable};
  endfunction

  task automatic idle_inputs();
    inst_opcode = 7'h00; inst_bit_30 = 1'b0; inst_bit_25 = 1'b0;
    inst_mem_ready = 1'b0; data_mem_ready = 1'b0; muldiv_done = 1'b0;
  endtask

  task automatic step();
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1'b0;
    #3;
    checks++; if (ctl() !== 8'h20) begin errors++; $display("FAIL reset_ctl got %h want %h", ctl(), 8'h20); end
    checks++; if ({illegal_instruction, mem_timeout} !== 2'b00) begin errors++;
      $display("FAIL reset_flags got %b want 00", {illegal_instruction, mem_timeout}); end
    checks++; if (alu_op_type !== 3'b000) begin errors++; $display("FAIL reset_alu got %b want 000", alu_op_type); end
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  task automatic test_addi();
    logic [7:0] exp_ctl [4];
    logic [2:0] exp_alu [4];
    exp_ctl = '{8'h60, 8'h00, 8'h00, 8'h90};
    exp_alu = '{3'b000, 3'b000, 3'b010, 3'b010};
    for (int c = 0; c < 4; c++) begin
      inst_mem_ready = (c == 0);
      // Garbage on the bus after fetch: decode must use the latched copy.
      inst_opcode = (c == 0) ? 7'h13 : 7'h7f;
      inst_bit_30 = (c != 0);
      @(negedge clock);
      checks++; if (ctl() !== exp_ctl[c]) begin errors++; $display("FAIL addi_ctl c%0d got %h want %h", c, ctl(), exp_ctl[c]); end
      checks++; if (alu_op_type !== exp_alu[c]) begin errors++; $display("FAIL addi_alu c%0d got %b want %b", c, alu_op_type, exp_alu[c]); end
      if (c == 2) begin
        checks++; if (alu_operand_b_select !== 1'b1) begin errors++; $display("FAIL addi_bsel got %b want 1", alu_operand_b_select); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_lw_delayed();
    logic [7:0] exp_ctl [8];
    int rd_cycles = 0;
    exp_ctl = '{8'h60, 8'h00, 8'h00, 8'h08, 8'h08, 8'h08, 8'h08, 8'h90};
    for (int c = 0; c < 8; c++) begin
      inst_mem_ready = (c == 0);
      inst_opcode    = (c == 0) ? 7'b0000011 : 7'h00;
      data_mem_ready = (c == 6);
      @(negedge clock);
      if (data_mem_read_enable) rd_cycles++;
      checks++; if (ctl() !== exp_ctl[c]) begin errors++; $display("FAIL lw_ctl c%0d got %h want %h", c, ctl(), exp_ctl[c]); end
      if (c == 7) begin
        checks++; if (reg_writeback_select !== 3'b001) begin errors++; $display("FAIL lw_wbsel got %b want 001", reg_writeback_select); end
        checks++; if (alu_op_type !== 3'b001) begin errors++; $display("FAIL lw_alu got %b want 001", alu_op_type); end
      end
      step();
    end
    checks++; if (rd_cycles != 4) begin errors++; $display("FAIL lw_rd_cycles got %0d want 4", rd_cycles); end
    idle_inputs();
  endtask

  task automatic test_mul();
    logic [7:0] exp_ctl [9];
    int starts = 0;
    exp_ctl = '{8'h60, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h90};
    for (int c = 0; c < 9; c++) begin
      inst_mem_ready = (c == 0);
      inst_opcode    = (c == 0) ? 7'b0110011 : 7'h00;
      inst_bit_25    = (c == 0);
      muldiv_done    = (c == 7);
      @(negedge clock);
      if (muldiv_start) starts++;
      checks++; if (ctl() !== exp_ctl[c]) begin errors++; $display("FAIL mul_ctl c%0d got %h want %h", c, ctl(), exp_ctl[c]); end
      if (c >= 2) begin
        checks++; if (alu_op_type !== 3'b101) begin errors++; $display("FAIL mul_alu c%0d got %b want 101", c, alu_op_type); end
      end
      step();
    end
    checks++; if (starts != 1) begin errors++; $display("FAIL mul_start_pulses got %0d want 1", starts); end
    idle_inputs();
  endtask

  task automatic test_branch_fence();
    logic [6:0] ops [2];
    logic [7:0] exec_ctl [2];
    logic [2:0] exec_alu [2];
    ops = '{7'b1100011, 7'b0001111};
    exec_ctl = '{8'h81, 8'h80};
    exec_alu = '{3'b001, 3'b000};
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < 3; c++) begin
        inst_mem_ready = (c == 0);
        inst_opcode    = (c == 0) ? ops[k] : 7'h00;
        @(negedge clock);
        if (c == 2) begin
          checks++; if (ctl() !== exec_ctl[k]) begin errors++; $display("FAIL br_ctl k%0d got %h want %h", k, ctl(), exec_ctl[k]); end
          checks++; if (alu_op_type !== exec_alu[k]) begin errors++; $display("FAIL br_alu k%0d got %b want %b", k, alu_op_type, exec_alu[k]); end
        end
        step();
      end
    end
    idle_inputs();
  endtask

  task automatic test_store();
    logic [7:0] exp_ctl [4];
    exp_ctl = '{8'h60, 8'h00, 8'h00, 8'h84};
    for (int c = 0; c < 4; c++) begin
      inst_mem_ready = (c == 0);
      inst_opcode    = (c == 0) ? 7'b0100011 : 7'h00;
      data_mem_ready = (c == 3);
      @(negedge clock);
      checks++; if (ctl() !== exp_ctl[c]) begin errors++; $display("FAIL sw_ctl c%0d got %h want %h", c, ctl(), exp_ctl[c]); end
      step();
    end
    idle_inputs();
  endtask

  typedef struct {
    logic [6:0] op;
    logic       b30;
    logic       b25;
    logic [9:0] exp;  // {alu_op, a_sel, b_sel, wb_sel, jal, jalr}
  } wb_vec_t;

  task automatic test_writeback_kinds();
    wb_vec_t v [5];
    logic [9:0] obs;
    v = '{'{7'b1101111, 1'b0, 1'b0, 10'b001_1_1_010_1_0},   // JAL
          '{7'b1100111, 1'b0, 1'b0, 10'b001_0_1_010_0_1},   // JALR
          '{7'b0110111, 1'b0, 1'b0, 10'b000_0_0_011_0_0},   // LUI
          '{7'b0010111, 1'b0, 1'b0, 10'b001_1_1_000_0_0},   // AUIPC
          '{7'b0110011, 1'b1, 1'b1, 10'b011_0_0_000_0_0}};  // SUB, bit30 wins over bit25
    for (int k = 0; k < 5; k++) begin
      for (int c = 0; c < 4; c++) begin
        inst_mem_ready = (c == 0);
        inst_opcode    = (c == 0) ? v[k].op : 7'h00;
        inst_bit_30    = (c == 0) && v[k].b30;
        inst_bit_25    = (c == 0) && v[k].b25;
        @(negedge clock);
        if (c == 3) begin
          obs = {alu_op_type, alu_operand_a_select, alu_operand_b_select,
                 reg_writeback_select, jal_enable, jalr_enable};
          checks++; if (ctl() !== 8'h90) begin errors++; $display("FAIL wb_ctl k%0d got %h want 90", k, ctl()); end
          checks++; if (obs !== v[k].exp) begin errors++; $display("FAIL wb_fields k%0d got %b want %b", k, obs, v[k].exp); end
        end
        step();
      end
    end
    idle_inputs();
  endtask

  task automatic test_fetch_wait_limit_ok();
    for (int c = 0; c < 8; c++) begin
      inst_mem_ready = (c == 4);
      inst_opcode    = (c == 4) ? 7'h13 : 7'h00;
      @(negedge clock);
      if (c == 4) begin
        checks++; if (ctl() !== 8'h60) begin errors++; $display("FAIL limit_ok_fetch got %h want 60", ctl()); end
      end
      if (c == 7) begin
        checks++; if (ctl() !== 8'h90) begin errors++; $display("FAIL limit_ok_wb got %h want 90", ctl()); end
        checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL limit_ok_timeout got %b want 0", mem_timeout); end
      end
      step();
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_store();
    logic [7:0] exp_ctl [4];
    exp_ctl = '{8'h60, 8'h00, 8'h00, 8'h04};
    for (int c = 0; c < 4; c++) begin
      inst_mem_ready = (c == 0);
      inst_opcode    = (c == 0) ? 7'b0100011 : 7'h00;
      @(negedge clock);
      checks++; if (ctl() !== exp_ctl[c]) begin errors++; $display("FAIL rst_sw_ctl c%0d got %h want %h", c, ctl(), exp_ctl[c]); end
      if (c < 3) step();
    end
    #2 reset = 1'b0;
    #1;
    checks++; if (ctl() !== 8'h20) begin errors++; $display("FAIL rst_sw_async got %h want 20", ctl()); end
    step();
    reset = 1'b1;
    @(negedge clock);
    checks++; if (ctl() !== 8'h20) begin errors++; $display("FAIL rst_sw_restart got %h want 20", ctl()); end
    step();
    idle_inputs();
  endtask

  task automatic test_illegal();
    int pcw = 0;
    for (int c = 0; c < 7; c++) begin
      inst_mem_ready = (c == 0) || (c >= 2);
      data_mem_ready = (c >= 2);
      muldiv_done    = (c >= 2);
      inst_opcode    = 7'b1111111;
      @(negedge clock);
      if (c >= 2 && pc_write_enable) pcw++;
      if (c == 1) begin
        checks++; if (illegal_instruction !== 1'b0) begin errors++; $display("FAIL ill_decode got %b want 0", illegal_instruction); end
      end
      if (c >= 2) begin
        checks++; if ({ctl(), illegal_instruction} !== 9'b0000_0000_1) begin errors++;
          $display("FAIL ill_trap c%0d got %h/%b want 00/1", c, ctl(), illegal_instruction); end
      end
      step();
    end
    checks++; if (pcw != 0) begin errors++; $display("FAIL ill_pc_writes got %0d want 0", pcw); end
    reset = 1'b0;
    #1;
    checks++; if (illegal_instruction !== 1'b0) begin errors++; $display("FAIL ill_clear got %b want 0", illegal_instruction); end
    step();
    reset = 1'b1;
    idle_inputs();
  endtask

  task automatic test_fetch_timeout();
    for (int c = 0; c < 8; c++) begin
      inst_mem_ready = (c >= 5);
      inst_opcode    = 7'h13;
      @(negedge clock);
      if (c < 5) begin
        checks++; if ({ctl(), mem_timeout} !== 9'b0010_0000_0) begin errors++;
          $display("FAIL to_wait c%0d got %h/%b want 20/0", c, ctl(), mem_timeout); end
      end else begin
        checks++; if ({ctl(), mem_timeout, illegal_instruction} !== 10'b0000_0000_1_0) begin errors++;
          $display("FAIL to_trap c%0d got %h/%b/%b want 00/1/0", c, ctl(), mem_timeout, illegal_instruction); end
      end
      step();
    end
    reset = 1'b0;
    #1;
    checks++; if (mem_timeout !== 1'b0) begin errors++; $display("FAIL to_clear got %b want 0", mem_timeout); end
    step();
    reset = 1'b1;
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_addi();
    test_lw_delayed();
    test_mul();
    test_branch_fence();
    test_store();
    test_writeback_kinds();
    test_fetch_wait_limit_ok();
    test_reset_mid_store();
    test_illegal();
    test_fetch_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have parameter M_EXTENSION, default 0; when 1, OP with bit 25 set selects the multiply/divide path.
REQ-002 SHALL have parameter MAX_MEM_WAIT, default 15; this is the maximum number of wait cycles per memory access before timeout, legal range 1..255.
REQ-003 SHALL have one clock and one asynchronous, active-low reset:
- clock  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low.
REQ-004 SHALL have these inputs:
- inst_opcode  in  7  opcode from instruction bus.
- inst_bit_30  in  1  ALU secondary-op select.
- inst_bit_25  in  1  M-extension select.
- inst_mem_ready  in  1  fetch data valid.
- data_mem_ready  in  1  data access complete.
- muldiv_done  in  1  multiplier/divider result valid.
REQ-005 SHALL have these outputs:
- pc_write_enable, ir_write_enable, inst_mem_read_enable, regfile_write_enable  out  1 each.
- alu_operand_a_select, alu_operand_b_select  out  1 each.
- alu_op_type  out  3.
- jal_enable, jalr_enable, branch_enable  out  1 each.
- data_mem_read_enable, data_mem_write_enable  out  1 each.
- reg_writeback_select  out  3.
- muldiv_start  out  1.
- illegal_instruction, mem_timeout  out  1 each.

Function
REQ-006 SHALL implement a Moore/Mealy FSM with states FETCH, DECODE, EXECUTE, MEM, MULDIV_WAIT, WRITEBACK, TRAP.
REQ-007 FETCH:
- inst_mem_read_enable=1.
- On inst_mem_ready=1: ir_write_enable=1 for that cycle; latch inst_opcode, inst_bit_30, inst_bit_25; go to DECODE.
- Decoding in all later states SHALL use only the latched copies.
REQ-008 DECODE: all enables 0. An unsupported opcode (not LOAD, MISC_MEM, OP_IMM, AUIPC, STORE, OP, LUI, BRANCH, JALR, JAL) goes to TRAP; any other opcode goes to EXECUTE.
REQ-009 alu_op_type encoding:
- 000 zero, 001 add, 010 default, 011 secondary, 101 M-extension.
- OP: bit30=1 gives 011; else if M_EXTENSION=1 and bit25=1 gives 101; else 010.
- OP_IMM: 010.
- LOAD, STORE, AUIPC, JAL, JALR, BRANCH: 001.
- LUI, MISC_MEM: 000.
- alu_operand_a_select=1 only for AUIPC and JAL.
- alu_operand_b_select=1 for LOAD, STORE, OP_IMM, AUIPC, JALR, JAL.
- These values SHALL be driven in EXECUTE, MEM, MULDIV_WAIT and WRITEBACK.
REQ-010 EXECUTE transitions:
- LOAD, STORE: go to MEM.
- OP with alu_op_type=101: pulse muldiv_start for exactly one cycle; go to MULDIV_WAIT.
- BRANCH: branch_enable=1, pc_write_enable=1; go to FETCH.
- MISC_MEM: pc_write_enable=1; go to FETCH.
- All others: go to WRITEBACK.
REQ-011 MEM:
- Hold data_mem_read_enable (LOAD) or data_mem_write_enable (STORE) until data_mem_ready=1.
- On ready, LOAD goes to WRITEBACK.
- On ready, STORE asserts pc_write_enable in that cycle and goes to FETCH.
REQ-012 MULDIV_WAIT: wait indefinitely for muldiv_done=1, then go to WRITEBACK. muldiv_start SHALL NOT re-assert.
REQ-013 WRITEBACK:
- regfile_write_enable=1 and pc_write_enable=1 for one cycle; go to FETCH.
- jal_enable=1 for JAL; jalr_enable=1 for JALR.
- reg_writeback_select: 001 LOAD; 010 JAL/JALR; 011 LUI; 000 otherwise.
REQ-014 Wait counter:
- Width $clog2(MAX_MEM_WAIT+1).
- Clears on entry to FETCH or MEM.
- Increments each cycle in FETCH or MEM while the relevant ready is 0.
- If the counter equals MAX_MEM_WAIT and ready is still 0, the FSM goes to TRAP and sets mem_timeout.
- Ready arriving on the same cycle the limit is reached counts as success.
REQ-015 TRAP: all enables 0. illegal_instruction or mem_timeout SHALL be sticky; only reset leaves TRAP.
REQ-016 Minimum latencies with zero-wait memory:
- OP/OP_IMM/LUI/AUIPC/JAL/JALR: 4 cycles.
- BRANCH/MISC_MEM: 3 cycles.
- STORE: 4 cycles.
- LOAD: 5 cycles.
REQ-017 Exactly one pc_write_enable pulse SHALL occur per retired instruction; none occur in TRAP.

Reset
REQ-018 reset=0 SHALL asynchronously force state=FETCH, counter=0, latched opcode=0, illegal_instruction=0, mem_timeout=0, and all other outputs to their state-decoded FETCH values.
REQ-019 Reset asserted mid-MEM or mid-MULDIV_WAIT SHALL abandon the access; after release, the first cycle SHALL be FETCH with inst_mem_read_enable=1.

Structure
REQ-020 The state enum, alu_op_type constants, reg_writeback_select constants and OPCODE_* constants SHALL live in the shared config package.
REQ-021 The block SHALL be a single module with no sub-modules; the wait counter is inline.

Verification
REQ-022 ADDI (0x00500093), zero-wait memory: FETCH, DECODE, EXECUTE, WRITEBACK; regfile_write_enable and pc_write_enable each high in cycle 4 only; alu_op_type=010.
REQ-023 LW with data_mem_ready delayed 3 cycles: data_mem_read_enable high for 4 cycles; WRITEBACK with select=001; total 8 cycles.
REQ-024 M_EXTENSION=1, MUL (bit25=1), muldiv_done after 5 cycles: one muldiv_start pulse; alu_op_type=101 held; regfile write follows done.
REQ-025 Opcode 7'b1111111 gives TRAP after DECODE; illegal_instruction=1 and stays 1; no further pc_write_enable; reset=0 clears it.
REQ-026 MAX_MEM_WAIT=4, inst_mem_ready held 0: mem_timeout=1 after 5 FETCH cycles. A second run with ready on the 5th cycle succeeds without a trap.
REQ-027 reset=0 pulsed mid-MEM of a STORE: data_mem_write_enable drops immediately (asynchronously); no pc_write_enable; FETCH restarts.
